// File: rtl/traffic_light_monitor.sv
// Passive watchdog on the traffic_light outputs: checks light encoding, road exclusion,
// per-road sequencing, minimum phase durations and farm-road starvation; sticky error flags.
module traffic_light_monitor #(
    parameter int GREEN_MIN  = 4,
    parameter int YELLOW_MIN = 3,
    parameter int MAX_WAIT   = 20,
    parameter int DUR_W      = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_highway,
    input  logic [2:0]       light_farm,
    input  logic             sensor,
    input  logic             err_clr,
    output logic [5:0]       err_flags,
    output logic             err_any,
    output logic             err_pulse,
    output logic [CNT_W-1:0] farm_serv_cnt
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int E_ENC      = 0;
    localparam int E_CONFLICT = 1;
    localparam int E_SEQ      = 2;
    localparam int E_SHORT_G  = 3;
    localparam int E_SHORT_Y  = 4;
    localparam int E_STARVE   = 5;

    localparam logic [DUR_W-1:0] GREEN_MIN_D  = DUR_W'(GREEN_MIN);
    localparam logic [DUR_W-1:0] YELLOW_MIN_D = DUR_W'(YELLOW_MIN);
    localparam logic [DUR_W-1:0] MAX_WAIT_D   = DUR_W'(MAX_WAIT);
    localparam logic [DUR_W-1:0] DUR_ZERO     = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0] DUR_ONE      = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0] DUR_MAX      = {DUR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    function automatic logic is_valid_code(input logic [2:0] code);
        case (code)
            RED, YELLOW, GREEN: is_valid_code = 1'b1;
            default:            is_valid_code = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_step(input logic [2:0] src, input logic [2:0] dst);
        is_legal_step = ((src == GREEN)  && (dst == YELLOW)) ||
                        ((src == YELLOW) && (dst == RED))    ||
                        ((src == RED)    && (dst == GREEN));
    endfunction

    function automatic logic [DUR_W-1:0] dur_inc(input logic [DUR_W-1:0] v);
        dur_inc = (v == DUR_MAX) ? v : v + DUR_ONE;
    endfunction

    // index 0 = highway, index 1 = farm road
    logic [1:0][2:0]       light_s;
    logic [1:0]            valid_s;
    logic [1:0][2:0]       prev_r;
    logic [1:0][2:0]       prev_n_s;
    logic [1:0]            prev_valid_r;
    logic [1:0]            prev_valid_n_s;
    logic [1:0][DUR_W-1:0] dur_r;
    logic [1:0][DUR_W-1:0] dur_n_s;
    logic [DUR_W-1:0]      wait_r;
    logic [DUR_W-1:0]      wait_n_s;
    logic [5:0]            new_err_s;
    logic [5:0]            flags_n_s;
    logic                  serv_s;
    logic [CNT_W-1:0]      cnt_n_s;

    assign light_s = {light_farm, light_highway};

    // Per-road history tracking and all violation detection for the current sample
    always_comb begin
        valid_s        = 2'b00;
        prev_n_s       = prev_r;
        prev_valid_n_s = prev_valid_r;
        dur_n_s        = dur_r;
        new_err_s      = 6'b000000;
        serv_s         = 1'b0;

        for (int r = 0; r < 2; r++) begin
            valid_s[r] = is_valid_code(light_s[r]);
            if (!valid_s[r]) begin
                // An unreadable sample breaks the history; prev state and duration are kept
                new_err_s[E_ENC]  = 1'b1;
                prev_valid_n_s[r] = 1'b0;
            end else begin
                prev_n_s[r]       = light_s[r];
                prev_valid_n_s[r] = 1'b1;
                if (prev_valid_r[r] && (light_s[r] == prev_r[r])) begin
                    dur_n_s[r] = dur_inc(dur_r[r]);
                end else begin
                    dur_n_s[r] = DUR_ONE;
                end
                if (prev_valid_r[r] && (light_s[r] != prev_r[r])) begin
                    new_err_s[E_SEQ]     = new_err_s[E_SEQ] | ~is_legal_step(prev_r[r], light_s[r]);
                    new_err_s[E_SHORT_G] = new_err_s[E_SHORT_G] |
                        ((prev_r[r] == GREEN) && (light_s[r] == YELLOW) && (dur_r[r] < GREEN_MIN_D));
                    new_err_s[E_SHORT_Y] = new_err_s[E_SHORT_Y] |
                        ((prev_r[r] == YELLOW) && (light_s[r] == RED) && (dur_r[r] < YELLOW_MIN_D));
                end else begin
                    new_err_s[E_SEQ] = new_err_s[E_SEQ];
                end
            end
        end

        new_err_s[E_CONFLICT] = valid_s[0] && valid_s[1] &&
                                (light_s[0] != RED) && (light_s[1] != RED);

        serv_s = prev_valid_r[1] && (prev_r[1] == RED) && (light_farm == GREEN);

        // Wait runs while a farm vehicle is unserved; starve fires only on reaching the limit
        if (sensor && (light_farm != GREEN)) begin
            wait_n_s = dur_inc(wait_r);
        end else begin
            wait_n_s = DUR_ZERO;
        end
        new_err_s[E_STARVE] = (wait_n_s == MAX_WAIT_D) && (wait_r != MAX_WAIT_D);

        flags_n_s = (err_clr ? 6'b000000 : err_flags) | new_err_s;
        cnt_n_s   = (serv_s && (farm_serv_cnt != CNT_MAX)) ? farm_serv_cnt + CNT_ONE : farm_serv_cnt;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r        <= {RED, RED};
            prev_valid_r  <= 2'b00;
            dur_r         <= {DUR_ZERO, DUR_ZERO};
            wait_r        <= DUR_ZERO;
            err_flags     <= 6'b000000;
            err_any       <= 1'b0;
            err_pulse     <= 1'b0;
            farm_serv_cnt <= {CNT_W{1'b0}};
        end else begin
            prev_r        <= prev_n_s;
            prev_valid_r  <= prev_valid_n_s;
            dur_r         <= dur_n_s;
            wait_r        <= wait_n_s;
            err_flags     <= flags_n_s;
            err_any       <= |flags_n_s;
            err_pulse     <= |new_err_s;
            farm_serv_cnt <= cnt_n_s;
        end
    end

endmodule
